dist_fetch_controller: RTL



---
 rtl/dist_fetch_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dist_fetch_controller.sv
// dist_fetch_controller: fetches one 256-bit distribution record from the
// off-chip sampler over SPI (mode 0) when the distribution datapath asks.
// The transaction is one command byte, one index byte, then 256 data bits.
//
// Handshake: a fetch starts only on a rising edge of req seen in IDLE (accept).
// stall is high from the accepting cycle through the DONE cycle. done pulses
// for exactly one cycle in DONE, and dist_out takes the new record in that
// same cycle. A req edge seen while busy is dropped, not queued.
module dist_fetch_controller #(
    parameter int         CLK_DIV  = 4,
    parameter logic [7:0] CMD_READ = 8'h03
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [7:0]   index,
    output logic         stall,
    output logic         done,
    output logic [255:0] dist_out,
    output logic         spi_cs_n,
    output logic         spi_sck,
    output logic         spi_mosi,
    input  logic         spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);

    state_t         state;
    state_t         state_next;
    logic           req_q;
    logic [7:0]     hcnt;      // clk cycles within the current SCK half-period
    logic [7:0]     bcnt;      // bit within the current phase; must reach 255
    logic           sck_q;
    logic [7:0]     sh;        // outgoing byte, MSB drives MOSI
    logic [7:0]     idx_q;
    logic [255:0]   buf_q;
    logic [255:0]   dist_q;

    logic accept;
    logic transfer;
    logic phase_end;
    logic rise;
    logic bit_end;
    logic last_bit;

    assign accept    = (state == S_IDLE) & req & ~req_q;
    assign transfer  = (state == S_CMD) | (state == S_ADDR) | (state == S_DATA);
    assign phase_end = (hcnt == HALF_MAX);
    // rise: this edge takes SCK 0->1 and samples MISO
    assign rise      = transfer & phase_end & ~sck_q;
    // bit_end: this edge takes SCK 1->0, closing the current bit
    assign bit_end   = transfer & phase_end & sck_q;
    assign last_bit  = (state == S_DATA) ? (bcnt == 8'd255) : (bcnt == 8'd7);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each transfer phase ends on the falling SCK edge of its last bit
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_CMD;
            S_CMD:  if (bit_end && last_bit) state_next = S_ADDR;
            S_ADDR: if (bit_end && last_bit) state_next = S_DATA;
            S_DATA: if (bit_end && last_bit) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: SCK timing, bit counting, shifters and the result register
    always_ff @(posedge clk) begin
        // req_q follows req even during reset, so a req held high through
        // reset is not mistaken for a fresh rising edge at release.
        req_q <= req;
        if (reset) begin
            hcnt   <= 8'd0;
            bcnt   <= 8'd0;
            sck_q  <= 1'b0;
            sh     <= 8'd0;
            idx_q  <= 8'd0;
            buf_q  <= '0;
            dist_q <= '0;
        end else if (accept) begin
            idx_q <= index;
            sh    <= CMD_READ;
            hcnt  <= 8'd0;
            bcnt  <= 8'd0;
            sck_q <= 1'b0;
        end else if (transfer) begin
            if (phase_end) begin
                hcnt  <= 8'd0;
                sck_q <= ~sck_q;
            end else begin
                hcnt <= hcnt + 8'd1;
            end
            if (rise && state == S_DATA) begin
                buf_q <= {buf_q[254:0], spi_miso};
            end
            if (bit_end) begin
                bcnt <= last_bit ? 8'd0 : bcnt + 8'd1;
                if (state == S_CMD && last_bit) begin
                    sh <= idx_q;
                end else begin
                    sh <= {sh[6:0], 1'b0};
                end
                // The final MISO sample was taken half a bit earlier, so buf_q is complete.
                if (state == S_DATA && last_bit) begin
                    dist_q <= buf_q;
                end
            end
        end
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        stall    = accept | (state != S_IDLE);
        done     = (state == S_DONE);
        spi_cs_n = ~transfer;
        spi_sck  = sck_q;
        spi_mosi = ((state == S_CMD) || (state == S_ADDR)) ? sh[7] : 1'b0;
        dist_out = dist_q;
    end

endmodule
